// File: rtl/b11_scrambler_pkg.sv
// Shared types and constants for the b11 input scrambler: FSM state encoding,
// OFFSET adjustments and the magnitude helper used when a result is emitted.
package b11_scrambler_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SAMPLE,
    S_CLASSIFY,
    S_SEED,
    S_MIX,
    S_REDUCE_UP,
    S_REDUCE_DN,
    S_OFFSET,
    S_EMIT
  } state_t;

  localparam int OFF_00 = -21;
  localparam int OFF_01 = -42;
  localparam int OFF_10 = 7;
  localparam int OFF_11 = 28;

  // Magnitude of a sign-extended accumulator; the caller truncates to its width.
  function automatic logic [31:0] abs_trunc(input logic signed [31:0] a);
    abs_trunc = a[31] ? 32'(-a) : 32'(a);
  endfunction

endpackage

// File: rtl/b11_scrambler_p.sv
// Input scrambler: samples a word, classifies it, folds it with a frame counter
// through a signed accumulator and emits the magnitude over valid/ready.
module b11_scrambler_p
  import b11_scrambler_pkg::*;
#(
  parameter int W      = 6,
  parameter int LIMIT  = 25,
  parameter int THRESH = 26,
  parameter int STEP   = 26
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] x_in,
  input  logic         stbi,
  input  logic         out_ready,
  output logic [W-1:0] x_out,
  output logic         out_valid,
  output logic         busy
);

  localparam int AW = W + 3;
  localparam logic signed [AW-1:0] THR_S   = AW'(THRESH);
  localparam logic signed [AW-1:0] STEP_S  = AW'(STEP);
  localparam logic signed [AW-1:0] NSTEP_S = AW'(-STEP);

  state_t                 state;
  logic [W-1:0]           cnt;
  logic [W-1:0]           r_in;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   r_ext;
  logic signed [AW-1:0]   cnt_ext;
  logic signed [AW-1:0]   off_s;

  // Operands enter the accumulator zero-extended.
  assign r_ext   = {3'b000, r_in};
  assign cnt_ext = {3'b000, cnt};
  assign busy    = (state != S_SAMPLE);

  always_comb begin
    off_s = AW'(OFF_00);
    case (r_in[3:2])
      2'b00:   off_s = AW'(OFF_00);
      2'b01:   off_s = AW'(OFF_01);
      2'b10:   off_s = AW'(OFF_10);
      default: off_s = AW'(OFF_11);
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      r_in      <= '0;
      x_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt   <= '0;
          state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          r_in <= x_in;
          if (!stbi) state <= S_CLASSIFY;
        end
        S_CLASSIFY: begin
          if (r_in == '0 || r_in == '1) begin
            cnt   <= (cnt_ext < AW'(LIMIT)) ? cnt + W'(1) : '0;
            acc   <= r_ext;
            state <= S_EMIT;
          end else if (r_ext <= THR_S) begin
            state <= S_SEED;
          end else begin
            state <= S_SAMPLE;
          end
        end
        S_SEED: begin
          acc   <= r_in[0] ? (cnt_ext << 1) : cnt_ext;
          state <= S_MIX;
        end
        S_MIX: begin
          if (r_in[1]) begin
            acc   <= r_ext + acc;
            state <= S_REDUCE_UP;
          end else begin
            acc   <= r_ext - acc;
            state <= S_REDUCE_DN;
          end
        end
        // Each iteration moves acc by STEP toward the bound, so both loops end.
        S_REDUCE_UP: begin
          if (acc > THR_S) acc <= acc - STEP_S;
          else             state <= S_OFFSET;
        end
        S_REDUCE_DN: begin
          if (acc < NSTEP_S) acc <= acc + STEP_S;
          else               state <= S_OFFSET;
        end
        S_OFFSET: begin
          acc   <= acc + off_s;
          state <= S_EMIT;
        end
        S_EMIT: begin
          // out_valid low marks the entry cycle; ready is only honoured afterwards.
          if (!out_valid) begin
            x_out     <= W'(abs_trunc(32'(acc)));
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_SAMPLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
